debug_load_latches: RTL and testbench

Host-to-MIPS counterpart of the debug frame serializer. While its CONTROLLER_ID is selected, it collects NB_LATCH-wide frames from the debug interface and reassembles them MSB-first into NB_OUTPUT_SIZE-bit words. It strips the trailing padding and issues one write per word to a MIPS-side memory, with an auto-incrementing address. It sits between the debug interface and the instruction/data memory load port and is used to download programs before a run.

---
 rtl/debug_load_latches.sv | 170 +++++++++++++++++
 tb/tb_debug_load_latches.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_load_latches.sv
// debug_load_latches
// Collects NB_LATCH-wide frames from the debug interface while CONTROLLER_ID is
// selected. It reassembles them MSB-first into NB_OUTPUT_SIZE-bit words, drops
// the LSB padding of the last frame, and issues one write per word to the
// MIPS-side memory. The write address increments after every word.
//
// Ports:
//   i_clock                 system clock, rising edge
//   i_reset                 asynchronous active-low reset
//   i_request_select        controller select from the debug interface
//   i_frame_from_interface  incoming frame
//   i_frame_valid           one-cycle strobe, frame valid this cycle
//   o_data_to_mips          reassembled word (held outside write cycles)
//   o_addr                  word address for o_data_to_mips (held)
//   o_write_enable          one-cycle write strobe
//   o_busy                  session active (collecting or writing)
//   o_full                  address space exhausted in current session
//   o_error                 sticky: last session ended with a partial word
module debug_load_latches #(
  parameter int unsigned NB_LATCH       = 32,
  parameter int unsigned NB_OUTPUT_SIZE = 32,
  parameter int unsigned NB_ADDR        = 10,
  parameter logic [5:0]  CONTROLLER_ID  = 6'b0000_01
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [5:0]                i_request_select,
  input  logic [NB_LATCH-1:0]       i_frame_from_interface,
  input  logic                      i_frame_valid,
  output logic [NB_OUTPUT_SIZE-1:0] o_data_to_mips,
  output logic [NB_ADDR-1:0]        o_addr,
  output logic                      o_write_enable,
  output logic                      o_busy,
  output logic                      o_full,
  output logic                      o_error
);

  localparam int unsigned NB_FRAMES = (NB_OUTPUT_SIZE + NB_LATCH - 1) / NB_LATCH;
  localparam int unsigned NB_PADDED = NB_FRAMES * NB_LATCH;
  localparam int unsigned NB_CNT    = (NB_FRAMES > 1) ? $clog2(NB_FRAMES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_FULL    = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [NB_CNT-1:0]         frame_cnt_q, frame_cnt_d;
  logic [NB_PADDED-1:0]      shift_q, shift_d;
  logic [NB_ADDR-1:0]        addr_q, addr_d;
  logic                      select_q;
  logic [NB_OUTPUT_SIZE-1:0] data_q, data_d;
  logic [NB_ADDR-1:0]        addr_out_q, addr_out_d;
  logic                      we_q, we_d;
  logic                      busy_q, busy_d;
  logic                      full_q, full_d;
  logic                      error_q, error_d;

  logic select_match_c;
  logic start_c;

  assign select_match_c = (i_request_select == CONTROLLER_ID);
  // Rising edge of the select opens a new session.
  assign start_c        = select_match_c & ~select_q;

  // State and output registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      select_q    <= 1'b0;
      data_q      <= '0;
      addr_out_q  <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      full_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      select_q    <= select_match_c;
      data_q      <= data_d;
      addr_out_q  <= addr_out_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      full_q      <= full_d;
      error_q     <= error_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    data_d      = data_q;
    addr_out_d  = addr_out_q;
    full_d      = full_q;
    error_d     = error_q;

    unique case (state_q)
      ST_IDLE: begin
        // A frame arriving together with the select edge is ignored.
        if (start_c) begin
          state_d     = ST_COLLECT;
          frame_cnt_d = '0;
          shift_d     = '0;
          addr_d      = '0;
          full_d      = 1'b0;
          error_d     = 1'b0;
        end
      end
      ST_COLLECT: begin
        // Deselect wins over a simultaneous frame.
        if (!select_match_c) begin
          state_d = ST_IDLE;
          if (frame_cnt_q != '0) begin
            error_d = 1'b1;
          end
          frame_cnt_d = '0;
        end else if (i_frame_valid) begin
          shift_d = (shift_q << NB_LATCH) | NB_PADDED'(i_frame_from_interface);
          if (frame_cnt_q == NB_CNT'(NB_FRAMES - 1)) begin
            frame_cnt_d = '0;
            state_d     = ST_WRITE;
            // Padding at the LSB end falls off here.
            data_d      = shift_d[NB_PADDED-1 -: NB_OUTPUT_SIZE];
            addr_out_d  = addr_q;
          end else begin
            frame_cnt_d = frame_cnt_q + NB_CNT'(1);
          end
        end
      end
      ST_WRITE: begin
        // Always one cycle; a deselect is handled by COLLECT afterwards.
        if (addr_q == '1) begin
          state_d = ST_FULL;
          full_d  = 1'b1;
        end else begin
          addr_d  = addr_q + NB_ADDR'(1);
          state_d = ST_COLLECT;
        end
      end
      ST_FULL: begin
        if (!select_match_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    we_d   = (state_d == ST_WRITE);
    busy_d = (state_d == ST_COLLECT) | (state_d == ST_WRITE);
  end

  assign o_data_to_mips = data_q;
  assign o_addr         = addr_out_q;
  assign o_write_enable = we_q;
  assign o_busy         = busy_q;
  assign o_full         = full_q;
  assign o_error        = error_q;

endmodule

// File: tb/tb_debug_load_latches.sv
// Bench for debug_load_latches: one default instance (32-bit words, 10-bit
// address) and one with 48-bit words and a 2-bit address, driven in parallel.
module tb_debug_load_latches;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  sel;
  logic [31:0] frame;
  logic        valid;

  logic [31:0] data_a;
  logic [9:0]  addr_a;
  logic        we_a, busy_a, full_a, err_a;
  logic [47:0] data_b;
  logic [1:0]  addr_b;
  logic        we_b, busy_b, full_b, err_b;

  always #5 clk = ~clk;

  debug_load_latches dut_a (
    .i_clock(clk), .i_reset(rst_n), .i_request_select(sel),
    .i_frame_from_interface(frame), .i_frame_valid(valid),
    .o_data_to_mips(data_a), .o_addr(addr_a), .o_write_enable(we_a),
    .o_busy(busy_a), .o_full(full_a), .o_error(err_a)
  );

  debug_load_latches #(.NB_LATCH(32), .NB_OUTPUT_SIZE(48), .NB_ADDR(2),
                       .CONTROLLER_ID(6'b000001)) dut_b (
    .i_clock(clk), .i_reset(rst_n), .i_request_select(sel),
    .i_frame_from_interface(frame), .i_frame_valid(valid),
    .o_data_to_mips(data_b), .o_addr(addr_b), .o_write_enable(we_b),
    .o_busy(busy_b), .o_full(full_b), .o_error(err_b)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: session-level view of each instance.
  // mode: 0 idle, 1 collecting, 2 writing this cycle, 3 address space full
  int          NF   [2] = '{1, 2};
  int          OUTW [2] = '{32, 48};
  int          AMAX [2] = '{1023, 3};
  int          mode [2] = '{0, 0};
  int          cnt  [2] = '{0, 0};
  int          maddr[2] = '{0, 0};
  int          mwadr[2] = '{0, 0};
  logic [63:0] acc  [2] = '{64'd0, 64'd0};
  logic [63:0] mdata[2] = '{64'd0, 64'd0};
  bit          merr [2] = '{0, 0};
  bit          mfull[2] = '{0, 0};
  bit          mselp[2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    bit          s;
    logic [63:0] mask;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mode[i] = 0; cnt[i] = 0; maddr[i] = 0; mwadr[i] = 0; acc[i] = '0;
        mdata[i] = '0; merr[i] = 0; mfull[i] = 0; mselp[i] = 0;
      end
    end else begin
      s = (sel == 6'd1);
      for (int i = 0; i < 2; i++) begin
        case (mode[i])
          0: if (s && !mselp[i]) begin
               mode[i] = 1; maddr[i] = 0; cnt[i] = 0; acc[i] = '0;
               merr[i] = 0; mfull[i] = 0;
             end
          1: if (!s) begin
               if (cnt[i] != 0) merr[i] = 1;
               cnt[i]  = 0;
               mode[i] = 0;
             end else if (valid) begin
               acc[i] = (acc[i] << 32) | 64'(frame);
               if (cnt[i] == NF[i] - 1) begin
                 mask     = (64'd1 << OUTW[i]) - 64'd1;
                 mdata[i] = (acc[i] >> (NF[i] * 32 - OUTW[i])) & mask;
                 mwadr[i] = maddr[i];
                 cnt[i]   = 0;
                 mode[i]  = 2;
               end else begin
                 cnt[i]++;
               end
             end
          2: if (maddr[i] == AMAX[i]) begin
               mode[i] = 3; mfull[i] = 1;
             end else begin
               maddr[i]++; mode[i] = 1;
             end
          default: if (!s) mode[i] = 0;
        endcase
        mselp[i] = s;
      end
    end
  end

  // Observed write logs, used by the directed scenarios.
  logic [63:0] wd0[$], wd1[$];
  int          wa0[$], wa1[$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic        g_we, g_busy, g_full, g_err;
      logic [63:0] g_data;
      int          g_addr;
      g_we   = (i == 0) ? we_a   : we_b;
      g_busy = (i == 0) ? busy_a : busy_b;
      g_full = (i == 0) ? full_a : full_b;
      g_err  = (i == 0) ? err_a  : err_b;
      g_data = (i == 0) ? 64'(data_a) : 64'(data_b);
      g_addr = (i == 0) ? int'(addr_a) : int'(addr_b);
      check($sformatf("we%0d", i),   64'(g_we),   64'(mode[i] == 2));
      check($sformatf("busy%0d", i), 64'(g_busy), 64'(mode[i] == 1 || mode[i] == 2));
      check($sformatf("full%0d", i), 64'(g_full), 64'(mfull[i]));
      check($sformatf("err%0d", i),  64'(g_err),  64'(merr[i]));
      if (mode[i] == 2) begin
        check($sformatf("data%0d", i), g_data, mdata[i]);
        check($sformatf("addr%0d", i), 64'(g_addr), 64'(mwadr[i]));
      end
      if (g_we) begin
        if (i == 0) begin wd0.push_back(g_data); wa0.push_back(g_addr); end
        else        begin wd1.push_back(g_data); wa1.push_back(g_addr); end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame followed by the mandatory idle gap cycle.
  task automatic send(input logic [31:0] f);
    frame = f; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
  endtask

  task automatic reselect();
    sel = 6'd0; tick(); tick();
    sel = 6'd1; tick();
  endtask

  initial begin
    int ba, bb;
    bit last_v;
    rst_n = 1'b0; sel = 6'd0; frame = '0; valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Two 32-bit words on the default instance
    sel = 6'd1; tick();
    ba = wd0.size(); bb = wd1.size();
    send(32'hDEADBEEF);
    send(32'h00000001);
    tick();
    check("t1_na", 64'(wd0.size() - ba), 64'd2);
    if (wd0.size() - ba == 2) begin
      check("t1_a0", 64'(wa0[ba]), 64'd0);
      check("t1_d0", wd0[ba], 64'hDEADBEEF);
      check("t1_a1", 64'(wa0[ba + 1]), 64'd1);
      check("t1_d1", wd0[ba + 1], 64'h00000001);
    end
    check("t1_err", 64'(err_a), 64'd0);
    check("t1_nb", 64'(wd1.size() - bb), 64'd1);
    if (wd1.size() - bb == 1) check("t1_db", wd1[bb], 64'hDEADBEEF0000);

    // 48-bit word from two frames, padding stripped
    reselect();
    bb = wd1.size();
    send(32'h12345678);
    send(32'h9ABC0000);
    check("t2_nb", 64'(wd1.size() - bb), 64'd1);
    if (wd1.size() - bb == 1) begin
      check("t2_db", wd1[bb], 64'h123456789ABC);
      check("t2_ab", 64'(wa1[bb]), 64'd0);
    end

    // Partial word then deselect sets error; reselect clears it
    reselect();
    bb = wd1.size();
    send(32'hCAFEF00D);
    sel = 6'd0; tick(); tick();
    check("t3_err", 64'(err_b), 64'd1);
    check("t3_busy", 64'(busy_b), 64'd0);
    check("t3_nb", 64'(wd1.size() - bb), 64'd0);
    check("t3_erra", 64'(err_a), 64'd0);
    sel = 6'd1; tick(); tick();
    check("t3_clr", 64'(err_b), 64'd0);
    send(32'h11112222); send(32'h33334444);
    check("t3_nb2", 64'(wd1.size() - bb), 64'd1);
    if (wd1.size() - bb == 1) check("t3_ab", 64'(wa1[bb]), 64'd0);

    // Address space of 4 words: fifth word is not written
    reselect();
    bb = wd1.size();
    for (int k = 0; k < 10; k++) send(32'h01000000 * 32'(k + 1));
    check("t4_nb", 64'(wd1.size() - bb), 64'd4);
    for (int k = 0; k < 4; k++)
      if (bb + k < wd1.size()) check($sformatf("t4_a%0d", k), 64'(wa1[bb + k]), 64'(k));
    check("t4_full", 64'(full_b), 64'd1);

    // Frame in deselect cycle dropped; frame in select-rising cycle ignored
    reselect();
    ba = wd0.size(); bb = wd1.size();
    send(32'hAAAA5555);
    sel = 6'd0; frame = 32'hBBBB6666; valid = 1'b1; tick();
    valid = 1'b0; tick();
    check("t5_errb", 64'(err_b), 64'd1);
    check("t5_erra", 64'(err_a), 64'd0);
    check("t5_na", 64'(wd0.size() - ba), 64'd1);
    check("t5_nb", 64'(wd1.size() - bb), 64'd0);
    ba = wd0.size();
    sel = 6'd1; frame = 32'hBAD0BAD0; valid = 1'b1; tick();
    valid = 1'b0; tick();
    send(32'h11111111);
    check("t5_na2", 64'(wd0.size() - ba), 64'd1);
    if (wd0.size() - ba == 1) begin
      check("t5_d", wd0[ba], 64'h11111111);
      check("t5_a", 64'(wa0[ba]), 64'd0);
    end

    // Async reset mid-word (dut_b holds one frame)
    bb = wd1.size();
    #1 rst_n = 1'b0;
    #1;
    check("t6_busy", 64'({busy_a, busy_b}), 64'd0);
    check("t6_we", 64'({we_a, we_b}), 64'd0);
    check("t6_data", 64'(data_a) | 64'(data_b), 64'd0);
    check("t6_flag", 64'({full_a, full_b, err_a, err_b, addr_a, addr_b}), 64'd0);
    sel = 6'd0; tick(); tick();
    rst_n = 1'b1; tick(); tick();
    check("t6_idle", 64'({busy_a, busy_b}), 64'd0);
    check("t6_nb", 64'(wd1.size() - bb), 64'd0);

    // Randomized traffic with occasional select changes
    last_v = 1'b0;
    sel = 6'd1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        if (sel == 6'd1) begin
          sel = 6'($urandom_range(0, 63));
          if (sel == 6'd1) sel = 6'd0;
        end else begin
          sel = 6'd1;
        end
      end
      valid  = !last_v && ($urandom_range(0, 2) == 0);
      frame  = $urandom();
      last_v = valid;
      tick();
    end
    valid = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
